synchronizer: RTL and testbench

SYNCHRONIZER -- requirements
Module: synchronizer

---
 rtl/synchronizer.sv | 51 +++++
 tb/tb_synchronizer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/synchronizer.sv
// Multi-stage flip-flop synchronizer for bringing asynchronous data into the clk domain.
// Each bit has its own register chain; a shadow of the output drives a one-cycle change flag.
module synchronizer #(
    parameter int              WIDTH       = 1,
    parameter int              STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             changed
);

    // Fewer than two stages gives no metastability protection, so clamp the depth at two.
    localparam int NSTAGE = (STAGES < 2) ? 2 : STAGES;

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [WIDTH-1:0] sync_q [NSTAGE];
    logic [WIDTH-1:0] sync_d [NSTAGE];
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;

    // Next state of the chain: stage 0 takes the raw input, each later stage takes its predecessor.
    always_comb begin
        sync_d[0] = in;
        for (int k = 1; k < NSTAGE; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        shadow_d = sync_q[NSTAGE-1];
    end

    // Stage and shadow registers; reset discards any data in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
            shadow_q <= RESET_VALUE;
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                sync_q[k] <= sync_d[k];
            end
            shadow_q <= shadow_d;
        end
    end

    // Both outputs depend only on registers, so nothing from in reaches them combinationally.
    assign out     = sync_q[NSTAGE-1];
    assign changed = |(sync_q[NSTAGE-1] ^ shadow_q);

endmodule

// File: tb/tb_synchronizer.sv
// Scoreboard bench for synchronizer: three instances (2, 4 and clamped-1 stages) share stimulus;
// a delay-line model pushes expected out/changed per edge and each test pops and compares.
module tb_synchronizer;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] in_s   = 8'h00;
    logic [7:0] out2, out4, out1;
    logic       ch2, ch4, ch1;

    int checks = 0;
    int errors = 0;

    logic [7:0] hist2[$], hist4[$];
    logic [7:0] sb2[$], sb4[$];
    logic       sbc2[$], sbc4[$];
    logic [7:0] prev2 = RV, prev4 = RV;

    always #5 clk = clk_en & ~clk;

    synchronizer #(.WIDTH(8), .STAGES(2), .RESET_VALUE(RV)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(in_s), .out(out2), .changed(ch2));
    synchronizer #(.WIDTH(8), .STAGES(4), .RESET_VALUE(RV)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in_s), .out(out4), .changed(ch4));
    synchronizer #(.WIDTH(8), .STAGES(1), .RESET_VALUE(RV)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in_s), .out(out1), .changed(ch1));

    task automatic model_reset();
        hist2.delete(); hist4.delete();
        sb2.delete(); sb4.delete(); sbc2.delete(); sbc4.delete();
        prev2 = RV; prev4 = RV;
    endtask

    // Drive one value, let one rising edge sample it, push the expected outputs, settle 1 time unit.
    task automatic tick(input logic [7:0] v);
        logic [7:0] e2, e4;
        in_s = v;
        @(posedge clk);
        hist2.push_back(v);
        hist4.push_back(v);
        if (hist2.size() > 2) hist2.delete(0);
        if (hist4.size() > 4) hist4.delete(0);
        e2 = (hist2.size() == 2) ? hist2[0] : RV;
        e4 = (hist4.size() == 4) ? hist4[0] : RV;
        sb2.push_back(e2); sbc2.push_back(e2 != prev2); prev2 = e2;
        sb4.push_back(e4); sbc4.push_back(e4 != prev4); prev4 = e4;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e2, e4;
        logic       c2, c4;
        in_s = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (out2 !== RV) begin errors++; $display("FAIL reset_noclk out2 got %h exp %h", out2, RV); end
        checks++; if (out4 !== RV) begin errors++; $display("FAIL reset_noclk out4 got %h exp %h", out4, RV); end
        checks++; if (out1 !== RV) begin errors++; $display("FAIL reset_noclk out1 got %h exp %h", out1, RV); end
        checks++; if ({ch2, ch4, ch1} !== 3'b000) begin errors++; $display("FAIL reset_noclk changed got %b exp 000", {ch2, ch4, ch1}); end
        model_reset();
        #4 rst_n = 1'b1;
        clk_en = 1'b1;
        // in=00 differs from RESET_VALUE at release: out updates after STAGES edges, changed pulses once
        for (int i = 0; i < 7; i++) begin
            tick(8'h00);
            e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
            checks++; if (out2 !== e2) begin errors++; $display("FAIL reset_release out2 got %h exp %h", out2, e2); end
            checks++; if (ch2 !== c2) begin errors++; $display("FAIL reset_release ch2 got %b exp %b", ch2, c2); end
            checks++; if (out4 !== e4) begin errors++; $display("FAIL reset_release out4 got %h exp %h", out4, e4); end
            checks++; if (ch4 !== c4) begin errors++; $display("FAIL reset_release ch4 got %b exp %b", ch4, c4); end
            checks++; if (out1 !== e2 || ch1 !== c2) begin errors++; $display("FAIL reset_release dut1 got %h/%b exp %h/%b", out1, ch1, e2, c2); end
        end
    endtask

    task automatic test_latency();
        logic [7:0] e2, e4;
        logic       c2, c4;
        for (int i = 0; i < 6; i++) begin
            tick(8'h3C);
            e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
            // Direct anchor: after edge 1 (i==1) the 2-stage output must already show 3C with changed high.
            if (i == 1) begin
                checks++; if (out2 !== 8'h3C || ch2 !== 1'b1) begin errors++; $display("FAIL latency_edge1 got %h/%b exp 3c/1", out2, ch2); end
            end
            checks++; if (out2 !== e2) begin errors++; $display("FAIL latency out2 got %h exp %h", out2, e2); end
            checks++; if (ch2 !== c2) begin errors++; $display("FAIL latency ch2 got %b exp %b", ch2, c2); end
            checks++; if (out4 !== e4) begin errors++; $display("FAIL latency out4 got %h exp %h", out4, e4); end
            checks++; if (ch4 !== c4) begin errors++; $display("FAIL latency ch4 got %b exp %b", ch4, c4); end
            checks++; if (out1 !== e2 || ch1 !== c2) begin errors++; $display("FAIL latency dut1 got %h/%b exp %h/%b", out1, ch1, e2, c2); end
        end
    endtask

    task automatic test_stages();
        logic [7:0] e2, e4;
        logic       c2, c4;
        for (int i = 0; i < 12; i++) begin
            tick((i < 6) ? 8'h3D : 8'h3C);
            e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
            checks++; if (out2 !== e2) begin errors++; $display("FAIL stages out2 got %h exp %h", out2, e2); end
            checks++; if (ch2 !== c2) begin errors++; $display("FAIL stages ch2 got %b exp %b", ch2, c2); end
            checks++; if (out4 !== e4) begin errors++; $display("FAIL stages out4 got %h exp %h", out4, e4); end
            checks++; if (ch4 !== c4) begin errors++; $display("FAIL stages ch4 got %b exp %b", ch4, c4); end
            checks++; if (out1 !== e2 || ch1 !== c2) begin errors++; $display("FAIL stages dut1 got %h/%b exp %h/%b", out1, ch1, e2, c2); end
        end
    endtask

    task automatic test_midflight_reset();
        logic [7:0] e2, e4;
        logic       c2, c4;
        tick(8'hFF);
        e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
        checks++; if (out2 !== e2 || out4 !== e4) begin errors++; $display("FAIL midflight_pre got %h/%h exp %h/%h", out2, out4, e2, e4); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out2 !== RV) begin errors++; $display("FAIL midflight_async out2 got %h exp %h", out2, RV); end
        checks++; if (out4 !== RV) begin errors++; $display("FAIL midflight_async out4 got %h exp %h", out4, RV); end
        checks++; if (out1 !== RV) begin errors++; $display("FAIL midflight_async out1 got %h exp %h", out1, RV); end
        checks++; if ({ch2, ch4, ch1} !== 3'b000) begin errors++; $display("FAIL midflight_async changed got %b exp 000", {ch2, ch4, ch1}); end
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(8'hFF);
            e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
            checks++; if (out2 !== e2) begin errors++; $display("FAIL midflight out2 got %h exp %h", out2, e2); end
            checks++; if (ch2 !== c2) begin errors++; $display("FAIL midflight ch2 got %b exp %b", ch2, c2); end
            checks++; if (out4 !== e4) begin errors++; $display("FAIL midflight out4 got %h exp %h", out4, e4); end
            checks++; if (ch4 !== c4) begin errors++; $display("FAIL midflight ch4 got %b exp %b", ch4, c4); end
            checks++; if (out1 !== e2 || ch1 !== c2) begin errors++; $display("FAIL midflight dut1 got %h/%b exp %h/%b", out1, ch1, e2, c2); end
        end
    endtask

    task automatic test_pulse();
        logic [7:0] e2, e4;
        logic       c2, c4;
        int         hi2 = 0;
        int         chg2 = 0;
        for (int i = 0; i < 14; i++) begin
            tick((i == 6) ? 8'hFF : 8'h00);
            e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
            if (i >= 6) begin
                if (out2 === 8'hFF) hi2++;
                if (ch2 === 1'b1) chg2++;
            end
            checks++; if (out2 !== e2) begin errors++; $display("FAIL pulse out2 got %h exp %h", out2, e2); end
            checks++; if (ch2 !== c2) begin errors++; $display("FAIL pulse ch2 got %b exp %b", ch2, c2); end
            checks++; if (out4 !== e4) begin errors++; $display("FAIL pulse out4 got %h exp %h", out4, e4); end
            checks++; if (ch4 !== c4) begin errors++; $display("FAIL pulse ch4 got %b exp %b", ch4, c4); end
            checks++; if (out1 !== e2 || ch1 !== c2) begin errors++; $display("FAIL pulse dut1 got %h/%b exp %h/%b", out1, ch1, e2, c2); end
        end
        checks++; if (hi2 != 1) begin errors++; $display("FAIL pulse_width out2 high cycles got %0d exp 1", hi2); end
        checks++; if (chg2 != 2) begin errors++; $display("FAIL pulse_changed ch2 pulses got %0d exp 2", chg2); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e2, e4;
        logic       c2, c4;
        for (int i = 0; i < 14; i++) begin
            tick((i < 8) ? 8'(i + 1) : 8'h08);
            e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
            checks++; if (out2 !== e2) begin errors++; $display("FAIL b2b out2 got %h exp %h", out2, e2); end
            checks++; if (ch2 !== c2) begin errors++; $display("FAIL b2b ch2 got %b exp %b", ch2, c2); end
            checks++; if (out4 !== e4) begin errors++; $display("FAIL b2b out4 got %h exp %h", out4, e4); end
            checks++; if (ch4 !== c4) begin errors++; $display("FAIL b2b ch4 got %b exp %b", ch4, c4); end
            checks++; if (out1 !== e2 || ch1 !== c2) begin errors++; $display("FAIL b2b dut1 got %h/%b exp %h/%b", out1, ch1, e2, c2); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e2, e4, v;
        logic       c2, c4;
        int         cyc = 0;
        int         hold;
        while (cyc < 10000) begin
            v    = 8'($urandom);
            hold = int'($urandom_range(4, 7));
            for (int h = 0; h < hold; h++) begin
                tick(v);
                cyc++;
                e2 = sb2.pop_front(); c2 = sbc2.pop_front(); e4 = sb4.pop_front(); c4 = sbc4.pop_front();
                checks++; if (out2 !== e2) begin errors++; $display("FAIL random out2 cyc %0d got %h exp %h", cyc, out2, e2); end
                checks++; if (ch2 !== c2) begin errors++; $display("FAIL random ch2 cyc %0d got %b exp %b", cyc, ch2, c2); end
                checks++; if (out4 !== e4) begin errors++; $display("FAIL random out4 cyc %0d got %h exp %h", cyc, out4, e4); end
                checks++; if (ch4 !== c4) begin errors++; $display("FAIL random ch4 cyc %0d got %b exp %b", cyc, ch4, c4); end
                checks++; if (out1 !== e2 || ch1 !== c2) begin errors++; $display("FAIL random dut1 cyc %0d got %h/%b exp %h/%b", cyc, out1, ch1, e2, c2); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stages();
        test_midflight_reset();
        test_pulse();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
